// File: rtl/transpose_tile_serializer_pkg.sv
// ---------------------------------------------------------------------------
// transpose_tile_serializer_pkg
// Shared transpose definitions: default element width and tile dimension,
// and the read-side state encoding used by the serializer and the switch
// wrapper.
// ---------------------------------------------------------------------------
package transpose_tile_serializer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;  // width of one matrix chunk
    localparam int DEFAULT_NUM_PE     = 8;   // tile is NUM_PE x NUM_PE chunks
    localparam int NUM_TILE_BUFS      = 2;   // ping-pong depth

    // IDLE: no tile buffered. DRAIN: at least one tile is being emitted.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_e;

endpackage

// File: rtl/transpose_tile_serializer_tile_buffer_bank.sv
// ---------------------------------------------------------------------------
// tile_buffer_bank
// Two full-tile registers (ping-pong). One tile-wide write port selected by
// i_wr_sel; one row-wide read mux selected by i_rd_sel / i_row_idx.
//
// Ports
//   clk        rising-edge clock
//   i_we       write the whole of i_tile into buffer i_wr_sel
//   i_wr_sel   buffer to write
//   i_tile     tile to store
//   i_rd_sel   buffer to read
//   i_row_idx  row to present
//   o_row      selected row (combinational read)
// ---------------------------------------------------------------------------
module tile_buffer_bank
    import transpose_tile_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PE     = DEFAULT_NUM_PE,
    parameter int IDX_W      = $clog2(NUM_PE)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_wr_sel,
    input  logic [DATA_WIDTH-1:0] i_tile [0:NUM_PE-1][0:NUM_PE-1],
    input  logic                  i_rd_sel,
    input  logic [IDX_W-1:0]      i_row_idx,
    output logic [DATA_WIDTH-1:0] o_row [0:NUM_PE-1]
);

    logic [DATA_WIDTH-1:0] r_buf [0:NUM_TILE_BUFS-1][0:NUM_PE-1][0:NUM_PE-1];

    // NOTE: the storage has no reset on purpose; its contents are only ever
    // observed through a buffer the control logic has marked as occupied.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int r = 0; r < NUM_PE; r++) begin
                for (int c = 0; c < NUM_PE; c++) begin
                    r_buf[i_wr_sel][r][c] <= i_tile[r][c];
                end
            end
        end
    end

    // NOTE: every element of o_row is assigned on every evaluation, so this
    // block is pure mux logic and cannot infer a latch.
    always_comb begin
        for (int c = 0; c < NUM_PE; c++) begin
            o_row[c] = r_buf[i_rd_sel][i_row_idx][c];
        end
    end

endmodule

// File: rtl/transpose_tile_serializer.sv
// ---------------------------------------------------------------------------
// transpose_tile_serializer
// Accepts whole tiles from the transpose switch into a two-deep ping-pong
// buffer and streams them out one row per accepted handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   tile_in   full NUM_PE x NUM_PE tile
//   tile_val  tile_in valid (single cycle)
//   tile_rdy  a tile buffer is free
//   row_out   current row of the tile being drained
//   row_val   row_out valid
//   row_rdy   downstream accepts the row
//   row_idx   row number of row_out within its tile
//   row_last  row_out is the final row of its tile
//   overflow  sticky: a tile arrived while both buffers were full
// ---------------------------------------------------------------------------
module transpose_tile_serializer
    import transpose_tile_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PE     = DEFAULT_NUM_PE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             tile_in [0:NUM_PE-1][0:NUM_PE-1],
    input  logic                              tile_val,
    output logic                              tile_rdy,
    output logic [DATA_WIDTH-1:0]             row_out [0:NUM_PE-1],
    output logic                              row_val,
    input  logic                              row_rdy,
    output logic [$clog2(NUM_PE)-1:0]         row_idx,
    output logic                              row_last,
    output logic                              overflow
);

    localparam int IDX_W = $clog2(NUM_PE);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PE - 1);

    rd_state_e        r_state;
    logic [1:0]       r_count;     // buffered tiles, 0..2
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [IDX_W-1:0] r_row_idx;
    logic             r_overflow;

    logic w_capture;    // tile accepted this edge
    logic w_drop;       // tile offered while full
    logic w_xfer;       // row accepted this edge
    logic w_last_xfer;  // final row of the tile accepted this edge

    // Ready comes from registered occupancy only: a buffer freed on this edge
    // is not offered to a tile arriving on the same edge.
    assign tile_rdy    = (r_count < 2'd2);
    assign w_capture   = tile_val && tile_rdy;
    assign w_drop      = tile_val && !tile_rdy;
    assign w_xfer      = row_val && row_rdy;
    assign w_last_xfer = w_xfer && (r_row_idx == LAST_ROW);

    assign row_val  = (r_state == DRAIN);
    assign row_idx  = r_row_idx;
    assign row_last = row_val && (r_row_idx == LAST_ROW);
    assign overflow = r_overflow;

    // Writes go to buffer wr_ptr only while a buffer is free; when one tile is
    // buffered wr_ptr != rd_ptr, so the buffer being read is never written.
    tile_buffer_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PE     (NUM_PE),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk       (clk),
        .i_we      (w_capture),
        .i_wr_sel  (r_wr_ptr),
        .i_tile    (tile_in),
        .i_rd_sel  (r_rd_ptr),
        .i_row_idx (r_row_idx),
        .o_row     (row_out)
    );

    // NOTE: every register here uses <= so all updates see the pre-edge
    // values of the pointers and count, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_row_idx  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_xfer) begin
                if (w_last_xfer) begin
                    r_row_idx <= '0;
                    r_rd_ptr  <= ~r_rd_ptr;
                end else begin
                    r_row_idx <= r_row_idx + 1'b1;
                end
            end

            // Capture and free on the same edge cancel out.
            case ({w_capture, w_last_xfer})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_xfer && !w_capture && (r_count == 2'd1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transpose_tile_serializer.sv
// ---------------------------------------------------------------------------
// tb_transpose_tile_serializer
// Directed bench, NUM_PE=4, DATA_WIDTH=16. Element (row r, col c) of tile t
// holds 16'h0trc, so every emitted row identifies its tile and row.
// ---------------------------------------------------------------------------
module tb_transpose_tile_serializer;

    localparam int DW  = 16;
    localparam int NPE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] tile_in [0:NPE-1][0:NPE-1];
    logic          tile_val = 1'b0;
    logic          tile_rdy;
    logic [DW-1:0] row_out [0:NPE-1];
    logic          row_val;
    logic          row_rdy = 1'b0;
    logic [1:0]    row_idx;
    logic          row_last;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    transpose_tile_serializer #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NPE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tile_in  (tile_in),
        .tile_val (tile_val),
        .tile_rdy (tile_rdy),
        .row_out  (row_out),
        .row_val  (row_val),
        .row_rdy  (row_rdy),
        .row_idx  (row_idx),
        .row_last (row_last),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tile_val = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_tile(input logic [3:0] id);
        for (int r = 0; r < NPE; r++) begin
            for (int c = 0; c < NPE; c++) begin
                tile_in[r][c] = {4'h0, id, 4'(r), 4'(c)};
            end
        end
        tile_val = 1'b1;
    endtask

    function automatic logic [63:0] exp_row(input logic [3:0] id, input int r);
        return {4'h0, id, 4'(r), 4'h0, 4'h0, id, 4'(r), 4'h1,
                4'h0, id, 4'(r), 4'h2, 4'h0, id, 4'(r), 4'h3};
    endfunction

    task automatic expect_row(input logic [3:0] id, input int r);
        string tag;
        tag = $sformatf("tile%0h_row%0d", id, r);
        check({tag, "_val"},  64'(row_val), 64'd1);
        check({tag, "_idx"},  64'(row_idx), 64'(r));
        check({tag, "_data"}, {row_out[0], row_out[1], row_out[2], row_out[3]}, exp_row(id, r));
        check({tag, "_last"}, 64'(row_last), (r == NPE - 1) ? 64'd1 : 64'd0);
    endtask

    // Expect rows first..NPE-1 of a tile on consecutive cycles (row_rdy=1).
    task automatic drain(input logic [3:0] id, input int first);
        for (int r = first; r < NPE; r++) begin
            expect_row(id, r);
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < NPE; r++) begin
            for (int c = 0; c < NPE; c++) begin
                tile_in[r][c] = '0;
            end
        end

        // Reset state
        do_reset();
        check("rst_row_val",  64'(row_val),  64'd0);
        check("rst_row_last", 64'(row_last), 64'd0);
        check("rst_tile_rdy", 64'(tile_rdy), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Single tile, row_rdy=1: rows on cycles 1..4, empty in cycle 5
        row_rdy = 1'b1;
        load_tile(4'hA);
        tick();
        tile_val = 1'b0;
        drain(4'hA, 0);
        check("single_empty_val", 64'(row_val), 64'd0);

        // Backpressure: row 0 held for three cycles, then full drain
        row_rdy = 1'b0;
        load_tile(4'hA);
        tick();
        tile_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_row(4'hA, 0);
            tick();
        end
        row_rdy = 1'b1;
        drain(4'hA, 0);
        check("bp_empty_val", 64'(row_val), 64'd0);

        // Ping-pong: A then B on consecutive edges, eight rows back to back
        load_tile(4'hA);
        tick();
        load_tile(4'hB);
        expect_row(4'hA, 0);
        tick();
        tile_val = 1'b0;
        check("pp_full_rdy", 64'(tile_rdy), 64'd0);
        drain(4'hA, 1);
        drain(4'hB, 0);
        check("pp_empty_val", 64'(row_val), 64'd0);
        check("pp_free_rdy",  64'(tile_rdy), 64'd1);

        // Overflow: C offered while both buffers are full
        row_rdy = 1'b0;
        load_tile(4'hA);
        tick();
        load_tile(4'hB);
        tick();
        load_tile(4'hC);
        tick();
        tile_val = 1'b0;
        check("ovf_set",      64'(overflow), 64'd1);
        check("ovf_full_rdy", 64'(tile_rdy), 64'd0);
        row_rdy = 1'b1;
        drain(4'hA, 0);
        drain(4'hB, 0);
        check("ovf_no_c_val", 64'(row_val),  64'd0);
        check("ovf_sticky",   64'(overflow), 64'd1);
        do_reset();
        check("ovf_cleared",  64'(overflow), 64'd0);

        // Simultaneous: C on A's last row with count==2 is dropped
        load_tile(4'hA);
        tick();
        load_tile(4'hB);
        expect_row(4'hA, 0);
        tick();
        tile_val = 1'b0;
        drain(4'hA, 1);
        // drain() ended after A2's cycle? No: it ran A1..A3. Redo A3 timing below.
        check("sim2_b_first_val", 64'(row_val), 64'd1);
        do_reset();

        load_tile(4'hA);
        tick();
        load_tile(4'hB);
        expect_row(4'hA, 0);
        tick();
        tile_val = 1'b0;
        expect_row(4'hA, 1);
        tick();
        expect_row(4'hA, 2);
        tick();
        expect_row(4'hA, 3);
        check("sim2_rdy_before", 64'(tile_rdy), 64'd0);
        load_tile(4'hC);
        tick();
        tile_val = 1'b0;
        check("sim2_ovf", 64'(overflow), 64'd1);
        expect_row(4'hB, 0);
        tick();
        expect_row(4'hB, 1);
        tick();
        expect_row(4'hB, 2);
        tick();
        // Simultaneous: C on B's last row with count==1 is captured
        expect_row(4'hB, 3);
        check("sim1_rdy_before", 64'(tile_rdy), 64'd1);
        load_tile(4'hC);
        tick();
        tile_val = 1'b0;
        check("sim1_rdy_after", 64'(tile_rdy), 64'd1);
        drain(4'hC, 0);
        check("sim1_empty_val", 64'(row_val), 64'd0);

        // Reset mid-drain with a tile and a row transfer on the same edge
        load_tile(4'hA);
        tick();
        tile_val = 1'b0;
        expect_row(4'hA, 0);
        tick();
        expect_row(4'hA, 1);
        tick();
        rst = 1'b1;
        load_tile(4'hC);
        tick();
        rst      = 1'b0;
        tile_val = 1'b0;
        check("mid_rst_val",  64'(row_val),  64'd0);
        check("mid_rst_last", 64'(row_last), 64'd0);
        check("mid_rst_rdy",  64'(tile_rdy), 64'd1);
        check("mid_rst_ovf",  64'(overflow), 64'd0);
        tick();
        check("mid_rst_no_capture", 64'(row_val), 64'd0);
        load_tile(4'hD);
        tick();
        tile_val = 1'b0;
        drain(4'hD, 0);
        check("mid_rst_empty_val", 64'(row_val), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/transpose_tile_serializer.md
TRANSPOSE_TILE_SERIALIZER -- requirements
Module: transpose_tile_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one matrix element chunk.
REQ-002 SHALL have parameter NUM_PE, default 8, tile dimension (NUM_PE x NUM_PE chunks); legal values are powers of two, 2 or greater.
REQ-003 SHALL have localparam IDX_W = $clog2(NUM_PE).
REQ-004 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port tile_in, input, unpacked [0:NUM_PE-1][0:NUM_PE-1] of DATA_WIDTH, full tile from the transpose switch output.
REQ-007 SHALL have port tile_val, input, 1, tile_in valid for one cycle (the switch out_val).
REQ-008 SHALL have port tile_rdy, output, 1, high when a tile buffer is free.
REQ-009 SHALL have port row_out, output, unpacked [0:NUM_PE-1] of DATA_WIDTH, the current row being presented.
REQ-010 SHALL have port row_val, output, 1, row_out valid.
REQ-011 SHALL have port row_rdy, input, 1, downstream accepts row.
REQ-012 SHALL have port row_idx, output, IDX_W, row number of row_out within its tile.
REQ-013 SHALL have port row_last, output, 1, high when row_idx == NUM_PE-1 and row_val is high.
REQ-014 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-015 SHALL hold two tile buffers (ping-pong), plus write pointer wr_ptr, read pointer rd_ptr and occupancy count (0..2).
REQ-016 SHALL set tile_rdy = (count < 2), combinationally from registered state; there is no same-cycle bypass of a buffer being freed.
REQ-017 SHALL capture tile_in into buffer[wr_ptr] at the edge where tile_val && tile_rdy, then toggle wr_ptr.
REQ-018 SHALL drive row_val = (count > 0), row_out = buffer[rd_ptr][row_idx] and row_idx from registered state; latency is a tile captured at edge N shows row 0 valid in the cycle after edge N.
REQ-019 SHALL count a row transfer when row_val && row_rdy, and increment row_idx on each transfer.
REQ-020 SHALL, on the transfer with row_idx == NUM_PE-1, wrap row_idx to 0, toggle rd_ptr and free that buffer.
REQ-021 SHALL keep row_out, row_idx and row_val stable while row_val && !row_rdy.
REQ-022 SHALL, when a capture and a last-row transfer happen in the same cycle, leave count unchanged and move both pointers.
REQ-023 SHALL ignore tile_val && !tile_rdy: the tile is dropped, no state changes, and overflow is set to 1; overflow stays 1 until rst.
REQ-024 SHALL implement a read state machine with two states. IDLE is count==0. DRAIN is count>0. IDLE goes to DRAIN on capture. DRAIN goes to IDLE on a last-row transfer with no simultaneous capture while count==1.
REQ-025 SHALL never modify a buffer while it is being read (rd_ptr buffer with count>0).

Reset
REQ-026 SHALL, on rst, clear count, wr_ptr, rd_ptr, row_idx and overflow to 0 and force the state to IDLE; row_val=0, row_last=0, tile_rdy=1 the cycle after reset.
REQ-027 SHALL let rst mid-drain discard all buffered tiles; buffer data contents need not be reset.
REQ-028 SHALL give rst priority over simultaneous tile_val or row transfer.

Structure
REQ-029 SHALL take DATA_WIDTH/NUM_PE defaults and the read-state enum (IDLE, DRAIN) from the shared transpose package, used also by the switch wrapper.
REQ-030 SHALL place one sub-module, tile_buffer_bank (two tile registers, one write port selected by wr_ptr, row read mux selected by rd_ptr/row_idx); control logic stays in the top.

Verification (NUM_PE=4, DATA_WIDTH=16, element value = 16'h{tile,row,col})
REQ-031 SHALL cover single tile with row_rdy=1: tile A at edge 0 -> rows 0..3 on cycles 1..4, row_last only in cycle 4, row_val=0 in cycle 5.
REQ-032 SHALL cover backpressure: row_rdy=0 for cycles 1..3 -> row_out=A row 0, row_idx=0, held constant; drains 4 rows once row_rdy=1.
REQ-033 SHALL cover ping-pong: tiles A and B on consecutive edges -> tile_rdy=0 after B; 8 rows emitted A0..A3, B0..B3 back-to-back.
REQ-034 SHALL cover overflow: a third tile C while count==2 -> C never emitted, overflow=1 and sticky, A and B output intact.
REQ-035 SHALL cover simultaneous events: tile C presented on the same edge as A's last-row transfer with count==2 -> C dropped (no bypass); with count==1 -> C captured, count stays 1, B then C follow.
REQ-036 SHALL cover reset mid-drain: rst after 2 rows of A -> next cycle row_val=0, tile_rdy=1, overflow=0; a new tile D then emits from row 0.
